// File: rtl/main_memory.sv
// Word-addressed backing memory behind the cache: bursted fills and writebacks with a fixed per-word latency.
// Define MAIN_MEMORY_STATS_EN to add saturating read_count/write_count outputs.
module main_memory #(
    parameter int ADDR_WIDTH    = 64,
    parameter int WORD_WIDTH    = 64,
    parameter int SIZE_BITS     = 10,
    parameter int BURST_LENGTH  = 1,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] din,
    output logic [WORD_WIDTH-1:0] dout,
    input  logic                  re,
    input  logic                  we,
    output logic                  ready
`ifdef MAIN_MEMORY_STATS_EN
    ,
    output logic [31:0]           read_count,
    output logic [31:0]           write_count
`endif
);

    localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int WAIT_W  = $clog2(LAT_MAX + 1);
    localparam int WORDS_W = $clog2(BURST_LENGTH + 1);
    localparam logic [WAIT_W-1:0]  RD_WAIT    = WAIT_W'(READ_LATENCY - 1);
    localparam logic [WAIT_W-1:0]  WR_WAIT    = WAIT_W'(WRITE_LATENCY - 1);
    localparam logic [WORDS_W-1:0] WORDS_INIT = WORDS_W'(BURST_LENGTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SIZE_BITS-1:0]   ptr_q, ptr_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [WORDS_W-1:0]     words_q, words_d;
    logic                   ready_q, ready_d;
    logic [WORD_WIDTH-1:0]  dout_q, dout_d;
    logic [WORD_WIDTH-1:0]  mem_q [2**SIZE_BITS];
    logic                   beat_s;
    logic                   unused_addr_s;

    assign unused_addr_s = ^addr[ADDR_WIDTH-1:SIZE_BITS];
    assign beat_s        = (state_q != ST_IDLE) && (wait_q == {WAIT_W{1'b0}});
    assign ready         = ready_q;
    assign dout          = dout_q;

    // Next-state for request accept, wait countdown and burst stepping
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wait_d  = wait_q;
        words_d = words_q;
        case (state_q)
            ST_IDLE: begin
                if (re) begin
                    state_d = ST_READ;
                    ptr_d   = addr[SIZE_BITS-1:0];
                    wait_d  = RD_WAIT;
                    words_d = WORDS_INIT;
                end else if (we) begin
                    state_d = ST_WRITE;
                    ptr_d   = addr[SIZE_BITS-1:0];
                    wait_d  = WR_WAIT;
                    words_d = WORDS_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ, ST_WRITE: begin
                if (!beat_s) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else if (words_q != {WORDS_W{1'b0}}) begin
                    ptr_d   = ptr_q + SIZE_BITS'(1);
                    words_d = words_q - WORDS_W'(1);
                    wait_d  = (state_q == ST_READ) ? RD_WAIT : WR_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs: ready and read data are prepared for the cycle they are presented in
    always_comb begin
        ready_d = (state_d == ST_IDLE) || (wait_d == {WAIT_W{1'b0}});
        if ((state_d == ST_READ) && (wait_d == {WAIT_W{1'b0}})) begin
            dout_d = mem_q[ptr_d];
        end else begin
            dout_d = dout_q;
        end
    end

    // Control state and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= {SIZE_BITS{1'b0}};
            wait_q  <= {WAIT_W{1'b0}};
            words_q <= {WORDS_W{1'b0}};
            ready_q <= 1'b0;
            dout_q  <= {WORD_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wait_q  <= wait_d;
            words_q <= words_d;
            ready_q <= ready_d;
            dout_q  <= dout_d;
        end
    end

    // Storage commit on a write beat; contents survive reset
    always_ff @(posedge clk) begin
        if (beat_s && (state_q == ST_WRITE)) begin
            mem_q[ptr_q] <= din;
        end
    end

`ifdef MAIN_MEMORY_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;
    logic        acc_rd_s;
    logic        acc_wr_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign acc_rd_s    = (state_q == ST_IDLE) && re;
    assign acc_wr_s    = (state_q == ST_IDLE) && !re && we;
    assign read_count  = rd_cnt_q;
    assign write_count = wr_cnt_q;

    // Accepted-request counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else begin
            if (acc_rd_s) begin
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end
            if (acc_wr_s) begin
                wr_cnt_q <= sat_inc(wr_cnt_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: three latency/burst configurations checked against a scoreboard.
module tb_main_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] addr_s [3];
    logic [63:0] din_s  [3];
    logic [63:0] dout_s [3];
    logic        re_s   [3];
    logic        we_s   [3];
    logic        ready_s[3];
`ifdef MAIN_MEMORY_STATS_EN
    logic [31:0] rc_s   [3];
    logic [31:0] wc_s   [3];
    int          exp_rd [3];
    int          exp_wr [3];
`endif

    int          lat_c [3] = '{4, 2, 1};
    int          bl_c  [3] = '{1, 4, 3};
    logic [63:0] model [3][1024];
    logic [63:0] sb_q  [$];
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    main_memory #(.BURST_LENGTH(1), .READ_LATENCY(4), .WRITE_LATENCY(4)) dut0 (
        .clk(clk), .rst(rst), .addr(addr_s[0]), .din(din_s[0]), .dout(dout_s[0]),
        .re(re_s[0]), .we(we_s[0]), .ready(ready_s[0])
`ifdef MAIN_MEMORY_STATS_EN
        , .read_count(rc_s[0]), .write_count(wc_s[0])
`endif
    );
    main_memory #(.BURST_LENGTH(4), .READ_LATENCY(2), .WRITE_LATENCY(2)) dut1 (
        .clk(clk), .rst(rst), .addr(addr_s[1]), .din(din_s[1]), .dout(dout_s[1]),
        .re(re_s[1]), .we(we_s[1]), .ready(ready_s[1])
`ifdef MAIN_MEMORY_STATS_EN
        , .read_count(rc_s[1]), .write_count(wc_s[1])
`endif
    );
    main_memory #(.BURST_LENGTH(3), .READ_LATENCY(1), .WRITE_LATENCY(1)) dut2 (
        .clk(clk), .rst(rst), .addr(addr_s[2]), .din(din_s[2]), .dout(dout_s[2]),
        .re(re_s[2]), .we(we_s[2]), .ready(ready_s[2])
`ifdef MAIN_MEMORY_STATS_EN
        , .read_count(rc_s[2]), .write_count(wc_s[2])
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic note_acc(input int i, input bit is_rd);
`ifdef MAIN_MEMORY_STATS_EN
        if (is_rd) exp_rd[i]++;
        else exp_wr[i]++;
`else
        if (is_rd) begin end else begin end
        if (i < 0) $display("bad instance %0d", i);
`endif
    endtask

    // Counts low-ready cycles until the next beat, bounded
    task automatic wait_beat(input int i, input int exp_low, input string tag);
        int n = 0;
        while (ready_s[i] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n), 64'(exp_low));
    endtask

    task automatic do_write(input int i, input logic [63:0] a, input logic [63:0] seed, input bit poke_re);
        int skip = 0;
        @(negedge clk);
        addr_s[i] = a; we_s[i] = 1'b1;
        @(negedge clk);
        we_s[i] = 1'b0;
        note_acc(i, 1'b0);
        if (poke_re) begin
            re_s[i] = 1'b1;
            @(negedge clk);
            re_s[i] = 1'b0;
            skip = 1;
        end
        for (int k = 0; k < bl_c[i]; k++) begin
            wait_beat(i, (k == 0) ? lat_c[i] - 1 - skip : lat_c[i] - 1, $sformatf("wr_lat%0d_b%0d", i, k));
            din_s[i] = seed + 64'(k);
            model[i][(int'(a[9:0]) + k) % 1024] = seed + 64'(k);
            @(negedge clk);
        end
        chk($sformatf("wr_idle%0d", i), 64'(ready_s[i]), 64'd1);
    endtask

    task automatic do_read(input int i, input logic [63:0] a);
        logic [63:0] e;
        for (int k = 0; k < bl_c[i]; k++) sb_q.push_back(model[i][(int'(a[9:0]) + k) % 1024]);
        @(negedge clk);
        addr_s[i] = a; re_s[i] = 1'b1;
        @(negedge clk);
        re_s[i] = 1'b0;
        note_acc(i, 1'b1);
        for (int k = 0; k < bl_c[i]; k++) begin
            wait_beat(i, lat_c[i] - 1, $sformatf("rd_lat%0d_b%0d", i, k));
            e = sb_q.pop_front();
            chk($sformatf("rd_data%0d_b%0d", i, k), dout_s[i], e);
            @(negedge clk);
        end
        chk($sformatf("rd_idle%0d", i), 64'(ready_s[i]), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] hold;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr_s[i] = 64'd0; din_s[i] = 64'd0; re_s[i] = 1'b0; we_s[i] = 1'b0;
`ifdef MAIN_MEMORY_STATS_EN
            exp_rd[i] = 0; exp_wr[i] = 0;
`endif
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready%0d", i), 64'(ready_s[i]), 64'd0);
            chk($sformatf("rst_dout%0d", i), dout_s[i], 64'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("idle_ready%0d", i), 64'(ready_s[i]), 64'd1);

        // Single-word write then read-back, including an address with upper bits set
        do_write(0, 64'd5, 64'hDEAD, 1'b0);
        do_read(0, 64'd5);
        do_read(0, 64'hABCD_0000_0000_0005);

        // Bursts wrapping the top of storage
        do_write(1, 64'd1022, 64'h1000, 1'b0);
        do_read(1, 64'd1022);
        do_write(2, 64'd1023, 64'h2000, 1'b0);
        do_read(2, 64'd1023);
        do_write(2, 64'd40, 64'h3000, 1'b0);
        do_read(2, 64'd40);

        // re and we together: read wins, storage untouched
        do_write(0, 64'd7, 64'h1111, 1'b0);
        sb_q.push_back(model[0][7]);
        @(negedge clk);
        addr_s[0] = 64'd7; din_s[0] = 64'h2222; re_s[0] = 1'b1; we_s[0] = 1'b1;
        @(negedge clk);
        re_s[0] = 1'b0; we_s[0] = 1'b0;
        note_acc(0, 1'b1);
        wait_beat(0, 3, "both_lat");
        hold = sb_q.pop_front();
        chk("both_data", dout_s[0], hold);
        @(negedge clk);
        do_read(0, 64'd7);

        // re during a write is dropped
        hold = dout_s[0];
        do_write(0, 64'd9, 64'h9999, 1'b1);
        for (int c = 0; c < 4; c++) begin
            chk("nord_ready", 64'(ready_s[0]), 64'd1);
            chk("nord_dout", dout_s[0], hold);
            @(negedge clk);
        end
        do_read(0, 64'd9);

        // Reset in the middle of a read burst
        do_read(1, 64'd1022);
        @(negedge clk);
        addr_s[1] = 64'd1022; re_s[1] = 1'b1;
        addr_s[0] = 64'd5;    re_s[0] = 1'b1;
        @(negedge clk);
        re_s[1] = 1'b0; re_s[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_ready0", 64'(ready_s[0]), 64'd0);
        chk("midrst_dout0", dout_s[0], 64'd0);
        chk("midrst_ready1", 64'(ready_s[1]), 64'd0);
        chk("midrst_dout1", dout_s[1], 64'd0);
        @(negedge clk);
        rst = 1'b1;
`ifdef MAIN_MEMORY_STATS_EN
        for (int i = 0; i < 3; i++) begin
            exp_rd[i] = 0; exp_wr[i] = 0;
        end
`endif
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("post_rst_ready%0d", i), 64'(ready_s[i]), 64'd1);
        do_read(0, 64'd5);
        do_read(1, 64'd1022);

`ifdef MAIN_MEMORY_STATS_EN
        do_read(2, 64'd1023);
        do_read(2, 64'd40);
        do_write(2, 64'd50, 64'h5000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rd_count%0d", i), 64'(rc_s[i]), 64'(exp_rd[i]));
            chk($sformatf("wr_count%0d", i), 64'(wc_s[i]), 64'(exp_wr[i]));
        end
        @(negedge clk);
        force dut0.rd_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut0.rd_cnt_q;
        do_read(0, 64'd5);
        chk("rd_count_sat", 64'(rc_s[0]), 64'h0000_0000_FFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
